// File: rtl/calc_exec_unit.sv
// calc_exec_unit: execute stage of the calculator.
// Latches operands and one-hot operation strobes on an accepted start.
// Computes add/sub/mul2/div2 in one registered cycle.
// Presents result/carry/err on a valid/ready handshake.
// Optional macro CALC_SAT_EN: saturating results; carry still reports the raw condition.
module calc_exec_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_add,
  input  logic             op_sub,
  input  logic             op_mul2,
  input  logic             op_div2,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       ops_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   sum_w, diff_w;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE accepts start, EXEC lasts one cycle, DONE waits for ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on accepted start; result registers load only in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      ops_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        a_q   <= op_a;
        b_q   <= op_b;
        ops_q <= {op_div2, op_mul2, op_sub, op_add};
      end
      if (state_q == EXEC) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        err_q    <= err_d;
      end
    end
  end

  // Arithmetic at WIDTH+1 bits from latched values; anything not one-hot is an error.
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    err_d    = 1'b0;
    sum_w    = {1'b0, a_q} + {1'b0, b_q};
    diff_w   = {1'b0, a_q} - {1'b0, b_q};
    case (ops_q)
      4'b0001: begin
        result_d = sum_w[WIDTH-1:0];
        carry_d  = sum_w[WIDTH];
`ifdef CALC_SAT_EN
        if (sum_w[WIDTH]) result_d = '1;
`endif
      end
      4'b0010: begin
        result_d = diff_w[WIDTH-1:0];
        carry_d  = diff_w[WIDTH];
`ifdef CALC_SAT_EN
        if (diff_w[WIDTH]) result_d = '0;
`endif
      end
      4'b0100: begin
        result_d = {a_q[WIDTH-2:0], 1'b0};
        carry_d  = a_q[WIDTH-1];
`ifdef CALC_SAT_EN
        if (a_q[WIDTH-1]) result_d = '1;
`endif
      end
      4'b1000: begin
        result_d = {1'b0, a_q[WIDTH-1:1]};
        carry_d  = a_q[0];
      end
      default: err_d = 1'b1;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign carry        = carry_q;
  assign err          = err_q;

endmodule

// File: tb/tb_calc_exec_unit.sv
// Self-checking bench for calc_exec_unit: directed cases plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_calc_exec_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_add = 1'b0, op_sub = 1'b0, op_mul2 = 1'b0, op_div2 = 1'b0;
  logic         busy;
  logic [W-1:0] result;
  logic         carry, err, result_valid;
  logic         result_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  calc_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .op_add(op_add), .op_sub(op_sub), .op_mul2(op_mul2), .op_div2(op_div2),
    .busy(busy), .result(result), .carry(carry), .err(err),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: ops = {div2, mul2, sub, add}.
  function automatic void model(input int a, input int b, input logic [3:0] ops,
                                output logic [W-1:0] r, output logic c, output logic e);
    int x;
    r = '0; c = 1'b0; e = 1'b0;
    if ($countones(ops) != 1) begin
      e = 1'b1;
      return;
    end
    if (ops[0]) begin
      x = a + b;
      c = (x >= 256);
      r = W'(x % 256);
`ifdef CALC_SAT_EN
      if (c) r = 8'd255;
`endif
    end else if (ops[1]) begin
      c = (a < b);
      x = (a - b + 256) % 256;
      r = W'(x);
`ifdef CALC_SAT_EN
      if (c) r = 8'd0;
`endif
    end else if (ops[2]) begin
      x = a * 2;
      c = (x >= 256);
      r = W'(x % 256);
`ifdef CALC_SAT_EN
      if (c) r = 8'd255;
`endif
    end else begin
      r = W'(a / 2);
      c = (a % 2 == 1);
    end
  endfunction

  task automatic set_ops(input logic [3:0] ops);
    {op_div2, op_mul2, op_sub, op_add} = ops;
  endtask

  // One full transaction: start, latency checks, optional stall, ack.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ops,
                        input int unsigned stall, input bit start_at_ack);
    logic [W-1:0] er;
    logic ec, ee;
    model(int'(a), int'(b), ops, er, ec, ee);
    @(negedge clk);
    op_a = a; op_b = b; set_ops(ops); start = 1'b1; result_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); set_ops(4'($urandom));
    check("busy_exec", busy, 1);
    check("valid_exec", result_valid, 0);
    @(posedge clk); #1;
    check("valid_done", result_valid, 1);
    check("result", result, er);
    check("carry", carry, ec);
    check("err", err, ee);
    for (int i = 0; i < int'(stall); i++) begin
      start = 1'b1;
      op_a = W'($urandom); op_b = W'($urandom); set_ops(4'b0001);
      @(posedge clk); #1;
      check("valid_stall", result_valid, 1);
      check("busy_stall", busy, 1);
      check("result_stall", result, er);
      check("carry_stall", carry, ec);
    end
    start = start_at_ack;
    result_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    result_ready = 1'b0;
    check("valid_ack", result_valid, 0);
    check("busy_ack", busy, 0);
    check("result_hold", result, er);
    check("err_hold", err, ee);
  endtask

  initial begin
    logic [3:0] ops;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    run_op(8'd100, 8'd27, 4'b0001, 0, 1'b0);
    run_op(8'd200, 8'd100, 4'b0001, 0, 1'b0);
    run_op(8'd5, 8'd9, 4'b0010, 0, 1'b0);
    run_op(8'hC1, 8'd0, 4'b0100, 0, 1'b0);
    run_op(8'd7, 8'd0, 4'b1000, 0, 1'b0);
    run_op(8'd60, 8'd3, 4'b0010, 5, 1'b1);
    run_op(8'd9, 8'd9, 4'b0011, 0, 1'b0);
    run_op(8'd9, 8'd9, 4'b0000, 0, 1'b0);

    // Reset while in EXEC discards the pending result.
    @(negedge clk);
    op_a = 8'd250; op_b = 8'd250; set_ops(4'b0001); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_carry", carry, 0);
    check("midrst_err", err, 0);
    @(posedge clk); #1;
    check("midrst_stays_idle", result_valid, 0);
    run_op(8'd10, 8'd20, 4'b0001, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: ops = 4'b0001;
        1: ops = 4'b0010;
        2: ops = 4'b0100;
        3: ops = 4'b1000;
        default: ops = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      endcase
      run_op(W'($urandom), W'($urandom), ops, $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
